// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle, single-issue CPU core with a parametrised register file,
// an inline ALU producing {Z,N,V,C}, and a one-access-per-instruction data-memory port.
// The FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequence lives in a single registered FSM.
// Optional feature macro: MC_CPU_CARRY_OPS_EN decodes ADC (0x0C) and SBC (0x0D), which use the current C flag.
module mc_cpu_core #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_instr_ready,
   input  logic              i_hold,
   input  logic [7:0]        i_opcode,
   input  logic [DATA_W-1:0] i_arg1,
   input  logic [DATA_W-1:0] i_arg2,
   output logic              o_instr_read,
   output logic              o_wait,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [3:0]        o_flags,
   output logic              o_illegal
);

   localparam int REG_AW = $clog2(NUM_REGS);

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_LDI = 8'h01;
   localparam logic [7:0] OP_LD  = 8'h02;
   localparam logic [7:0] OP_ST  = 8'h03;
   localparam logic [7:0] OP_MOV = 8'h04;
   localparam logic [7:0] OP_ADD = 8'h07;
   localparam logic [7:0] OP_SUB = 8'h08;
   localparam logic [7:0] OP_AND = 8'h09;
   localparam logic [7:0] OP_OR  = 8'h0A;
   localparam logic [7:0] OP_XOR = 8'h0B;
   localparam logic [7:0] OP_ADC = 8'h0C;
   localparam logic [7:0] OP_SBC = 8'h0D;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK} state_t;

   state_t              state_q;
   logic [7:0]          opcode_q;
   logic [REG_AW-1:0]   rd_q;
   logic [DATA_W-1:0]   arg2_q;
   logic [DATA_W-1:0]   regFile_q [NUM_REGS];
   logic [DATA_W-1:0]   opA_q;
   logic [DATA_W-1:0]   opB_q;
   logic [DATA_W-1:0]   result_q;
   logic [3:0]          aluFlags_q;
   logic [DATA_W-1:0]   data_q;
   logic [3:0]          flags_q;
   logic                instrRead_q;
   logic                illegal_q;
   logic                memRd_q;
   logic                memWr_q;
   logic [ADDR_W-1:0]   memAddr_q;
   logic [DATA_W-1:0]   memWdata_q;

   logic [REG_AW-1:0]   rsIdx;
   logic                isAluOp;
   logic                carryIn;
   logic [DATA_W:0]     sumWide;
   logic [DATA_W:0]     diffWide;
   logic [DATA_W-1:0]   aluRes_d;
   logic [3:0]          aluFlags_d;
   logic                aluC;
   logic                aluV;
   logic                unusedArg1;

   assign rsIdx      = arg2_q[REG_AW-1:0];
   assign unusedArg1 = ^i_arg1;

   // Classify the latched opcode as an ALU operation (goes through EXECUTE and updates flags).
   always_comb begin
      isAluOp = 1'b0;
      case (opcode_q)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: isAluOp = 1'b1;
`ifdef MC_CPU_CARRY_OPS_EN
         OP_ADC, OP_SBC: isAluOp = 1'b1;
`endif
         default: isAluOp = 1'b0;
      endcase
   end

   // ALU: one extra bit on the add/subtract gives carry out or borrow directly; carry-in only exists for ADC/SBC builds.
   always_comb begin
      carryIn = 1'b0;
`ifdef MC_CPU_CARRY_OPS_EN
      if (opcode_q == OP_ADC || opcode_q == OP_SBC) begin
         carryIn = flags_q[0];
      end
`endif
      sumWide  = {1'b0, opA_q} + {1'b0, opB_q} + {{DATA_W{1'b0}}, carryIn};
      diffWide = {1'b0, opA_q} - {1'b0, opB_q} - {{DATA_W{1'b0}}, carryIn};
      aluRes_d = '0;
      aluC     = 1'b0;
      aluV     = 1'b0;
      case (opcode_q)
         OP_ADD, OP_ADC: begin
            aluRes_d = sumWide[DATA_W-1:0];
            aluC     = sumWide[DATA_W];
            aluV     = (opA_q[DATA_W-1] == opB_q[DATA_W-1]) && (aluRes_d[DATA_W-1] != opA_q[DATA_W-1]);
         end
         OP_SUB, OP_SBC: begin
            aluRes_d = diffWide[DATA_W-1:0];
            aluC     = diffWide[DATA_W];
            aluV     = (opA_q[DATA_W-1] != opB_q[DATA_W-1]) && (aluRes_d[DATA_W-1] != opA_q[DATA_W-1]);
         end
         OP_AND:  aluRes_d = opA_q & opB_q;
         OP_OR:   aluRes_d = opA_q | opB_q;
         OP_XOR:  aluRes_d = opA_q ^ opB_q;
         default: aluRes_d = '0;
      endcase
      aluFlags_d = {(aluRes_d == '0), aluRes_d[DATA_W-1], aluV, aluC};
   end

   // Core sequencer: all architectural state and every output register advance here.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= FETCH;
         opcode_q    <= '0;
         rd_q        <= '0;
         arg2_q      <= '0;
         opA_q       <= '0;
         opB_q       <= '0;
         result_q    <= '0;
         aluFlags_q  <= '0;
         data_q      <= '0;
         flags_q     <= '0;
         instrRead_q <= 1'b0;
         illegal_q   <= 1'b0;
         memRd_q     <= 1'b0;
         memWr_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         instrRead_q <= 1'b0;
         illegal_q   <= 1'b0;
         case (state_q)
            FETCH: begin
               if (i_instr_ready && !i_hold) begin
                  opcode_q    <= i_opcode;
                  rd_q        <= i_arg1[REG_AW-1:0];
                  arg2_q      <= i_arg2;
                  instrRead_q <= 1'b1;
                  state_q     <= DECODE;
               end
            end
            DECODE: begin
               opA_q <= regFile_q[rd_q];
               opB_q <= regFile_q[rsIdx];
               if (isAluOp) begin
                  state_q <= EXECUTE;
               end else begin
                  case (opcode_q)
                     OP_NOP: state_q <= FETCH;
                     OP_LDI: begin
                        result_q <= arg2_q;
                        state_q  <= WRITEBACK;
                     end
                     OP_MOV: begin
                        result_q <= regFile_q[rsIdx];
                        state_q  <= WRITEBACK;
                     end
                     OP_LD: begin
                        memRd_q   <= 1'b1;
                        memAddr_q <= arg2_q[ADDR_W-1:0];
                        state_q   <= MEM;
                     end
                     OP_ST: begin
                        memWr_q    <= 1'b1;
                        memAddr_q  <= arg2_q[ADDR_W-1:0];
                        memWdata_q <= regFile_q[rd_q];
                        state_q    <= MEM;
                     end
                     default: begin
                        illegal_q <= 1'b1;
                        state_q   <= FETCH;
                     end
                  endcase
               end
            end
            EXECUTE: begin
               result_q   <= aluRes_d;
               aluFlags_q <= aluFlags_d;
               state_q    <= WRITEBACK;
            end
            MEM: begin
               if (i_mem_ready) begin
                  memRd_q <= 1'b0;
                  memWr_q <= 1'b0;
                  if (memRd_q) begin
                     result_q <= i_mem_rdata;
                     state_q  <= WRITEBACK;
                  end else begin
                     state_q  <= FETCH;
                  end
               end
            end
            WRITEBACK: begin
               regFile_q[rd_q] <= result_q;
               data_q          <= result_q;
               if (isAluOp) begin
                  flags_q <= aluFlags_q;
               end
               state_q <= FETCH;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign o_instr_read = instrRead_q;
   assign o_wait       = (state_q != FETCH);
   assign o_mem_rd     = memRd_q;
   assign o_mem_wr     = memWr_q;
   assign o_mem_addr   = memAddr_q;
   assign o_mem_wdata  = memWdata_q;
   assign o_data       = data_q;
   assign o_flags      = flags_q;
   assign o_illegal    = illegal_q;

endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multi-cycle, single-issue CPU core. It fetches one instruction per handshake from the instruction source, reads operands from an internal register file, and executes on an inline ALU with Z/N/V/C flags. It performs at most one data-memory access per instruction and writes results back. It replaces the fixed 8-bit core, adding:
- configurable data width and register count
- a data-memory load/store path
- carry-chained arithmetic
- illegal-opcode reporting

## Interface
Parameters:
- DATA_W, 8: datapath, register and immediate width (≥4).
- NUM_REGS, 8: register count; power of two, ≥2. REG_AW = $clog2(NUM_REGS).
- ADDR_W, 8: data-memory address width (≤ DATA_W).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_instr_ready  in  1  instruction source has a valid instruction.
- i_hold  in  1  stall; blocks new fetches only.
- i_opcode  in  8  opcode.
- i_arg1  in  DATA_W  first argument (rd/rs index in low REG_AW bits).
- i_arg2  in  DATA_W  second argument (register index, immediate or address).
- o_instr_read  out  1  one-cycle accept pulse.
- o_wait  out  1  core busy (state ≠ FETCH).
- o_mem_rd  out  1  data-memory read request.
- o_mem_wr  out  1  data-memory write request.
- o_mem_addr  out  ADDR_W  data-memory address.
- o_mem_wdata  out  DATA_W  store data.
- i_mem_rdata  in  DATA_W  load data, valid when i_mem_ready.
- i_mem_ready  in  1  memory completes current request.
- o_data  out  DATA_W  last written-back value.
- o_flags  out  4  {Z,N,V,C}.
- o_illegal  out  1  one-cycle pulse on undefined opcode.

## Operation
States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.

Opcodes (rd = arg1[REG_AW-1:0], rs = arg2[REG_AW-1:0]):
- 0x00 NOP
- 0x01 LDI rd←arg2
- 0x02 LD rd←mem[arg2[ADDR_W-1:0]]
- 0x03 ST mem[arg2]←rd
- 0x04 MOV rd←rs
- 0x07 ADD
- 0x08 SUB rd←rd−rs
- 0x09 AND
- 0x0A OR
- 0x0B XOR
- 0x0C ADC, 0x0D SBC (only with the configuration macro, see Configuration).

Transitions:
- FETCH: if i_instr_ready && !i_hold, latch opcode/args, pulse o_instr_read, go to DECODE; else stay.
- DECODE: read operands.
  - ALU op → EXECUTE.
  - LD/ST → MEM.
  - LDI/MOV → WRITEBACK.
  - NOP → FETCH.
  - Undefined opcode → pulse o_illegal, FETCH; no state change.
- EXECUTE: compute result and flags into holding registers, then → WRITEBACK.
- MEM: assert o_mem_rd (LD) or o_mem_wr (ST) with o_mem_addr/o_mem_wdata stable until the edge sampling i_mem_ready=1.
  - LD captures i_mem_rdata on that edge → WRITEBACK.
  - ST → FETCH.
- WRITEBACK: write rd, update o_data; ALU ops also update o_flags. → FETCH.

Arithmetic, all modulo 2^DATA_W:
- Z = result==0; N = result[DATA_W-1].
- ADD/ADC: C = carry out.
- SUB/SBC: C = borrow (1 when unsigned subtrahend+borrow-in > minuend).
- V = signed overflow.
- AND/OR/XOR clear C and V.
- LDI/LD/MOV/ST leave flags unchanged.
- rd==rs is legal (e.g. SUB r,r → 0, Z=1).

## Timing
- Instruction latency in cycles, counting the accept cycle:
  - NOP/illegal: 2
  - LDI/MOV: 3
  - ALU op: 4
  - ST: 3 + memory wait cycles
  - LD: 4 + memory wait cycles
- Zero-wait memory means i_mem_ready is high in the first MEM cycle.
- Register writes land at the WRITEBACK edge, so the next instruction always sees the new value; no forwarding is needed.
- i_hold is sampled only in FETCH; an in-flight instruction completes regardless. i_instr_ready with i_hold=1 is not accepted and o_instr_read stays 0.
- i_mem_ready outside MEM is ignored. o_mem_rd/o_mem_wr drop in the cycle after the completing edge and are never both high.
- Reset values (reset may arrive in any state, including mid-MEM):
  - state FETCH
  - all registers 0, o_data 0, o_flags 0
  - o_instr_read 0, o_mem_rd 0, o_mem_wr 0, o_illegal 0, o_mem_addr 0, o_mem_wdata 0
  - o_wait 0
- An aborted store is not retried.

## Configuration
- MC_CPU_CARRY_OPS_EN defined: 0x0C ADC (rd←rd+rs+C) and 0x0D SBC (rd←rd−rs−C) are decoded, using the current C flag.
- MC_CPU_CARRY_OPS_EN undefined: 0x0C/0x0D are undefined opcodes (o_illegal pulse, no state change) and no carry-in logic is built.

## Test plan
- Reset, then LDI r1,0x05; LDI r2,0x03; SUB r1,r2 → o_data 0x02, flags Z0 N0 V0 C0; ALU op accept-to-FETCH is 4 cycles.
- ADD r1,r2 with r1=0xFF, r2=0x01 (DATA_W=8) → 0x00, Z1 C1; then ADC r3,r3 with r3=0 → r3=0x01 with macro, o_illegal pulse and r3 unchanged without.
- ST r1,0x40 then LD r4,0x40 with i_mem_ready delayed 3 cycles → o_mem_wr/o_mem_rd held 4 cycles with address 0x40; r4 equals stored value.
- i_hold=1 with i_instr_ready=1 for 5 cycles → no o_instr_read; release → accept in next cycle.
- Assert i_rst during MEM of LD → next cycle o_mem_rd=0, o_wait=0, all registers 0.
- DATA_W=16, NUM_REGS=16: ADD 0x7FFF+0x0001 in r15 → 0x8000, N1 V1 C0.
